// File: rtl/mac_params.sv
// XGMII character constants, lane geometry and framer state encoding.
// Shared by the framer, its bus interface and any block that talks XGMII.
package mac_params;

  localparam int N_CHANNELS = 4;
  localparam int W_BYTE     = 8;
  localparam int W_WORD     = N_CHANNELS * W_BYTE;

  localparam logic [W_BYTE-1:0] XGMII_IDLE  = 8'h07;
  localparam logic [W_BYTE-1:0] XGMII_START = 8'hFB;
  localparam logic [W_BYTE-1:0] XGMII_TERM  = 8'hFD;
  localparam logic [W_BYTE-1:0] XGMII_ERR   = 8'hFE;
  localparam logic [W_BYTE-1:0] XGMII_PRE   = 8'h55;
  localparam logic [W_BYTE-1:0] XGMII_SFD   = 8'hD5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_DRAIN,
    S_IFG
  } framer_state_t;

  function automatic logic [W_WORD-1:0] rep_byte(
    input logic [W_BYTE-1:0] b
  );
    return {N_CHANNELS{b}};
  endfunction

endpackage

// File: rtl/mac_tx_framer_if.sv
// Buffer-read and XGMII signal bundle around the TX framer.
// master = framer side, slave = buffer / PHY side.
interface mac_tx_framer_if;
  import mac_params::*;

  logic                  ren;
  logic [N_CHANNELS-1:0] rctrl;
  logic [W_WORD-1:0]     rdata;
  logic                  empty;
  logic [N_CHANNELS-1:0] xgmii_ctrl;
  logic [W_WORD-1:0]     xgmii_data;

  modport master (
    output ren,
    input  rctrl,
    input  rdata,
    input  empty,
    output xgmii_ctrl,
    output xgmii_data
  );

  modport slave (
    input  ren,
    output rctrl,
    output rdata,
    output empty,
    input  xgmii_ctrl,
    input  xgmii_data
  );

endinterface

// File: rtl/mac_tx_framer.sv
// Frames buffer lines onto 32-bit XGMII: start, preamble, data, terminate, IFG.
// Ports: i_clk/i_reset/i_clk_en, buffer read (o_ren,i_rctrl,i_rdata,i_empty), o_xgmii_*.
module mac_tx_framer
  import mac_params::*;
#(
  parameter int N_IFG_WORDS = 3
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clk_en,
  output logic                  o_ren,
  input  logic [N_CHANNELS-1:0] i_rctrl,
  input  logic [W_WORD-1:0]     i_rdata,
  input  logic                  i_empty,
  output logic [N_CHANNELS-1:0] o_xgmii_ctrl,
  output logic [W_WORD-1:0]     o_xgmii_data
);

  localparam int CW = $clog2(N_IFG_WORDS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N_IFG_WORDS - 1);
  localparam logic [N_CHANNELS-1:0] ALL_V = '1;

  framer_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N_CHANNELS-1:0] ctrl_d;
  logic [W_WORD-1:0] data_d;
  logic pop;

  // Terminate word for the head line. Only contiguous low-lane
  // patterns keep data; anything else becomes FD 07 07 07.
  logic [1:0] term_k;
  logic [N_CHANNELS-1:0] term_ctrl;
  logic [W_WORD-1:0] term_data;

  always_comb begin
    term_k = 2'd0;
    case (i_rctrl)
      4'b0001: term_k = 2'd1;
      4'b0011: term_k = 2'd2;
      4'b0111: term_k = 2'd3;
      default: term_k = 2'd0;
    endcase
    term_ctrl = '0;
    term_data = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      if (i < int'(term_k)) begin
        term_data[i*W_BYTE +: W_BYTE] =
          i_rdata[i*W_BYTE +: W_BYTE];
      end else if (i == int'(term_k)) begin
        term_ctrl[i] = 1'b1;
        term_data[i*W_BYTE +: W_BYTE] = XGMII_TERM;
      end else begin
        term_ctrl[i] = 1'b1;
        term_data[i*W_BYTE +: W_BYTE] = XGMII_IDLE;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = '1;
    data_d  = rep_byte(XGMII_IDLE);
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!i_empty) begin
          if (i_rctrl == '0) begin
            pop = 1'b1;
          end else begin
            ctrl_d  = 4'b0001;
            data_d  = {XGMII_PRE, XGMII_PRE,
                       XGMII_PRE, XGMII_START};
            state_d = S_PREAMBLE;
          end
        end
      end
      S_PREAMBLE: begin
        ctrl_d  = '0;
        data_d  = {XGMII_SFD, XGMII_PRE,
                   XGMII_PRE, XGMII_PRE};
        state_d = S_DATA;
      end
      S_DATA: begin
        if (i_empty) begin
          data_d  = rep_byte(XGMII_ERR);
          state_d = S_DRAIN;
        end else begin
          pop = 1'b1;
          if (i_rctrl == ALL_V) begin
            ctrl_d = '0;
            data_d = i_rdata;
          end else begin
            ctrl_d  = term_ctrl;
            data_d  = term_data;
            cnt_d   = '0;
            state_d = S_IFG;
          end
        end
      end
      S_DRAIN: begin
        // Throw away the rest of an underrun frame.
        if (!i_empty) begin
          pop = 1'b1;
          if (i_rctrl != ALL_V) begin
            cnt_d   = '0;
            state_d = S_IFG;
          end
        end
      end
      S_IFG: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_ren = i_clk_en & ~i_reset & pop & ~i_empty;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      o_xgmii_ctrl <= '1;
      o_xgmii_data <= rep_byte(XGMII_IDLE);
    end else if (i_clk_en) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      o_xgmii_ctrl <= ctrl_d;
      o_xgmii_data <= data_d;
    end
  end

endmodule

// File: tb/tb_mac_tx_framer.sv
// Bench for mac_tx_framer: buffer model, expected XGMII word stream.
// Directed frames, random frames, clock-enable gating, underrun, reset.
module tb_mac_tx_framer;
  import mac_params::*;

  localparam int NIFG = 3;
  localparam logic [35:0] IDLE_W = {4'hF, 32'h07070707};

  typedef struct packed {
    logic [3:0]  c;
    logic [31:0] d;
  } line_t;

  logic clk = 1'b0;
  logic rst;
  logic en;

  mac_tx_framer_if bus ();

  mac_tx_framer #(.N_IFG_WORDS(NIFG)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_clk_en     (en),
    .o_ren        (bus.ren),
    .i_rctrl      (bus.rctrl),
    .i_rdata      (bus.rdata),
    .i_empty      (bus.empty),
    .o_xgmii_ctrl (bus.xgmii_ctrl),
    .o_xgmii_data (bus.xgmii_data)
  );

  always #5 clk = ~clk;

  line_t       buf_q[$];
  logic [35:0] got[$];
  logic [35:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // One clock: present the buffer head, watch o_ren, pop, sample.
  task automatic step(logic e);
    logic r;
    bus.empty = (buf_q.size() == 0);
    if (buf_q.size() != 0) begin
      bus.rctrl = buf_q[0].c;
      bus.rdata = buf_q[0].d;
    end else begin
      bus.rctrl = 4'hF;
      bus.rdata = $urandom;
    end
    en = e;
    #1;
    r = bus.ren;
    if (!e) chk("ren_when_disabled", 64'(r), 64'd0);
    if (bus.empty) chk("ren_when_empty", 64'(r), 64'd0);
    if (rst) chk("ren_in_reset", 64'(r), 64'd0);
    @(posedge clk);
    if (r && buf_q.size() != 0) void'(buf_q.pop_front());
    #1;
    if (e) got.push_back({bus.xgmii_ctrl, bus.xgmii_data});
  endtask

  task automatic run(int n, bit toggle);
    for (int i = 0; i < n; i++)
      step(toggle ? (i % 2 == 0) : 1'b1);
  endtask

  // Queue one frame in the buffer and its expected wire words.
  task automatic add_frame(int nfull, logic [3:0] endc,
                           bit stray);
    line_t l;
    logic [31:0] td;
    logic [3:0] tc;
    int k;
    if (stray) begin
      l.c = 4'h0;
      l.d = $urandom;
      buf_q.push_back(l);
      exp_q.push_back(IDLE_W);
    end
    exp_q.push_back({4'b0001, 32'h555555FB});
    exp_q.push_back({4'b0000, 32'hD5555555});
    for (int i = 0; i < nfull; i++) begin
      l.c = 4'hF;
      l.d = $urandom;
      buf_q.push_back(l);
      exp_q.push_back({4'b0000, l.d});
    end
    l.c = endc;
    l.d = $urandom;
    buf_q.push_back(l);
    k = (endc == 4'b0001) ? 1 :
        (endc == 4'b0011) ? 2 :
        (endc == 4'b0111) ? 3 : 0;
    for (int i = 0; i < 4; i++) begin
      if (i < k) begin
        td[i*8 +: 8] = l.d[i*8 +: 8];
        tc[i] = 1'b0;
      end else begin
        td[i*8 +: 8] = (i == k) ? 8'hFD : 8'h07;
        tc[i] = 1'b1;
      end
    end
    exp_q.push_back({tc, td});
    for (int i = 0; i < NIFG; i++) exp_q.push_back(IDLE_W);
  endtask

  task automatic compare_stream(string tag);
    logic [35:0] e;
    chk({tag, "_len"}, 64'(got.size() >= exp_q.size()), 64'd1);
    for (int i = 0; i < got.size(); i++) begin
      e = (i < exp_q.size()) ? exp_q[i] : IDLE_W;
      chk($sformatf("%s_w%0d", tag, i), 64'(got[i]), 64'(e));
    end
    chk({tag, "_drained"}, 64'(buf_q.size()), 64'd0);
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    int nf;
    int nfull;
    logic [3:0] endc;
    line_t l;

    rst = 1'b1;
    en  = 1'b0;
    bus.empty = 1'b1;
    bus.rctrl = 4'hF;
    bus.rdata = '0;
    step(1'b0);
    step(1'b0);
    chk("reset_ctrl", 64'(bus.xgmii_ctrl), 64'hF);
    chk("reset_data", 64'(bus.xgmii_data), 64'h07070707);
    rst = 1'b0;
    run(3, 1'b0);
    got.delete();

    add_frame(2, 4'b0011, 1'b0);
    run(14, 1'b0);
    compare_stream("frame_0011");

    add_frame(1, 4'b0000, 1'b0);
    run(12, 1'b0);
    compare_stream("frame_0000");

    add_frame(3, 4'b0111, 1'b0);
    add_frame(2, 4'b0001, 1'b0);
    run(24, 1'b0);
    compare_stream("back_to_back");

    for (int it = 0; it < 8; it++) begin
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) begin
        nfull = $urandom_range(0, 5);
        endc  = 4'($urandom_range(0, 14));
        if (nfull == 0 && endc == 4'h0) endc = 4'b0001;
        add_frame(nfull, endc, ($urandom_range(0, 3) == 0));
      end
      run(45, 1'b0);
      compare_stream($sformatf("rand%0d", it));
    end

    add_frame(2, 4'b0011, 1'b0);
    add_frame(1, 4'b0000, 1'b0);
    run(44, 1'b1);
    compare_stream("clk_en_1010");

    l.c = 4'hF;
    l.d = $urandom;
    buf_q.push_back(l);
    exp_q.push_back({4'b0001, 32'h555555FB});
    exp_q.push_back({4'b0000, 32'hD5555555});
    exp_q.push_back({4'b0000, l.d});
    exp_q.push_back({4'hF, 32'hFEFEFEFE});
    run(4, 1'b0);
    for (int i = 0; i < 2; i++) begin
      l.d = $urandom;
      buf_q.push_back(l);
    end
    l.c = 4'b0011;
    buf_q.push_back(l);
    run(14, 1'b0);
    compare_stream("underrun");

    add_frame(1, 4'b0001, 1'b0);
    run(10, 1'b0);
    compare_stream("after_underrun");

    add_frame(4, 4'b0011, 1'b0);
    run(4, 1'b0);
    got.delete();
    exp_q.delete();
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    chk("midframe_reset_word", 64'(got[0]), 64'(IDLE_W));
    got.delete();
    buf_q.delete();
    add_frame(2, 4'b0111, 1'b0);
    run(12, 1'b0);
    compare_stream("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
